// File: rtl/ws2812_pkg.sv
// Shared types and default sizing for the WS2812 frame scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ws2812_pkg;

    localparam int LED_CNT_DEF = 7;
    localparam int PIX_W_DEF   = 9;
    localparam int FRAME_W     = LED_CNT_DEF * PIX_W_DEF;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        START,
        ACK,
        SEND,
        GAP
    } sched_state_t;

endpackage

// File: rtl/sched_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
// Latency: load takes effect on the next cycle; done is combinational from the count.
// Backpressure: none; en pauses counting, load always wins.
module sched_timer #(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/ws2812_frame_scheduler.sv
// Double-buffers SPI frames (or a chase pattern on SPI silence) and launches the WS2812 driver.
// Latency: frame_valid while IDLE -> drv_start three cycles later; drv_data updates only in LATCH.
// Backpressure: none upstream; newer frames overwrite a pending one (counted in drop_cnt).
module ws2812_frame_scheduler
    import ws2812_pkg::*;
#(
    parameter int LED_CNT  = LED_CNT_DEF,
    parameter int PIX_W    = PIX_W_DEF,
    parameter int GAP_CYC  = 3000,
    parameter int IDLE_CYC = 10000000,
    parameter int STEP_CYC = 1000000,
    parameter int ACK_CYC  = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [LED_CNT*PIX_W-1:0] frame_in,
    input  logic                     frame_valid,
    input  logic                     drv_busy,
    output logic                     drv_start,
    output logic [LED_CNT*PIX_W-1:0] drv_data,
    output logic                     pattern_active,
    output logic                     stall_err,
    output logic [7:0]               drop_cnt
);

    localparam int FW     = LED_CNT * PIX_W;
    localparam int GA_MAX = (GAP_CYC > ACK_CYC) ? GAP_CYC : ACK_CYC;
    localparam int GA_W   = $clog2(GA_MAX + 1);
    localparam int IDLE_W = $clog2(IDLE_CYC + 1);
    localparam int STEP_W = $clog2(STEP_CYC + 1);
    localparam int IDX_W  = (LED_CNT > 1) ? $clog2(LED_CNT) : 1;

    sched_state_t state, state_nxt;

    logic [FW-1:0]    staging;
    logic [FW-1:0]    pat_frame;
    logic             pending;
    logic             pend_pat;
    logic [IDX_W-1:0] pat_idx;
    logic [IDX_W-1:0] pat_sel;

    logic             ga_load;
    logic [GA_W-1:0]  ga_val;
    logic             ga_done;
    logic             stall_set;
    logic             idle_done;
    logic             step_done;
    logic             step_fire;
    logic             drop_hit;

    // GAP and ACK never overlap, so one timer serves both windows.
    sched_timer #(.W(GA_W)) u_ga_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ga_load),
        .load_val (ga_val),
        .en       ((state == ACK) || (state == GAP)),
        .done     (ga_done)
    );

    sched_timer #(.W(IDLE_W), .RST_VAL(IDLE_W'(IDLE_CYC))) u_idle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (frame_valid),
        .load_val (IDLE_W'(IDLE_CYC)),
        .en       (1'b1),
        .done     (idle_done)
    );

    // Held at zero while inactive so the first step is queued as pattern mode begins.
    sched_timer #(.W(STEP_W)) u_step_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (step_fire || !pattern_active),
        .load_val (step_fire ? STEP_W'(STEP_CYC - 1) : '0),
        .en       (pattern_active),
        .done     (step_done)
    );

    // A due step waits while a frame is still pending, so every index reaches the LEDs.
    assign step_fire = pattern_active && step_done && !pending && !frame_valid;

    // Only an unsent SPI frame counts as dropped; LATCH is already consuming the old one.
    assign drop_hit = frame_valid && pending && !pend_pat && (state != LATCH);

    always_comb begin
        pat_frame = '0;
        for (int i = 0; i < LED_CNT; i++) begin
            if (pat_sel == IDX_W'(i)) begin
                pat_frame[FW-1-i*PIX_W -: PIX_W] = {PIX_W{1'b1}};
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ga_load   = 1'b0;
        ga_val    = '0;
        drv_start = 1'b0;
        stall_set = 1'b0;
        unique case (state)
            IDLE: begin
                if (pending) state_nxt = LATCH;
            end
            LATCH: begin
                state_nxt = START;
            end
            START: begin
                // The ack window counts the START cycle itself.
                drv_start = 1'b1;
                state_nxt = ACK;
                ga_load   = 1'b1;
                ga_val    = GA_W'(ACK_CYC - 2);
            end
            ACK: begin
                if (drv_busy) begin
                    state_nxt = SEND;
                end else if (ga_done) begin
                    stall_set = 1'b1;
                    state_nxt = GAP;
                    ga_load   = 1'b1;
                    ga_val    = GA_W'(GAP_CYC - 1);
                end
            end
            SEND: begin
                if (!drv_busy) begin
                    state_nxt = GAP;
                    ga_load   = 1'b1;
                    ga_val    = GA_W'(GAP_CYC - 1);
                end
            end
            GAP: begin
                if (ga_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            staging        <= '0;
            drv_data       <= '0;
            pending        <= 1'b0;
            pend_pat       <= 1'b0;
            pattern_active <= 1'b0;
            stall_err      <= 1'b0;
            drop_cnt       <= '0;
            pat_idx        <= '0;
            pat_sel        <= '0;
        end else begin
            state <= state_nxt;

            if (stall_set) stall_err <= 1'b1;

            if (state == LATCH) begin
                drv_data <= pattern_active ? pat_frame : staging;
            end

            if (frame_valid) begin
                staging  <= frame_in;
                pending  <= 1'b1;
                pend_pat <= 1'b0;
                if (drop_hit && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
            end else if (step_fire) begin
                pending  <= 1'b1;
                pend_pat <= 1'b1;
                pat_sel  <= pat_idx;
                pat_idx  <= (pat_idx == IDX_W'(LED_CNT - 1)) ? '0 : pat_idx + 1'b1;
            end else if (state == LATCH) begin
                pending <= 1'b0;
            end

            if (frame_valid) begin
                pattern_active <= 1'b0;
            end else if (idle_done) begin
                pattern_active <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ws2812_frame_scheduler.sv
// Self-checking bench for ws2812_frame_scheduler with a 10-cycle busy driver model.
module tb_ws2812_frame_scheduler;

    localparam int LED_CNT  = 7;
    localparam int PIX_W    = 9;
    localparam int FW       = LED_CNT * PIX_W;
    localparam int GAP_CYC  = 8;
    localparam int IDLE_CYC = 50;
    localparam int STEP_CYC = 20;
    localparam int ACK_CYC  = 4;
    localparam int BUSY_CYC = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [FW-1:0] frame_in = '0;
    logic          frame_valid = 1'b0;
    logic          drv_busy = 1'b0;
    logic          drv_start;
    logic [FW-1:0] drv_data;
    logic          pattern_active;
    logic          stall_err;
    logic [7:0]    drop_cnt;

    int            n_tests = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            last_fv_cyc = 0;
    int            exp_drop = 0;
    bit            bfm_ack = 1'b1;
    int            st_cyc_q[$];
    logic [FW-1:0] st_dat_q[$];

    ws2812_frame_scheduler #(
        .LED_CNT(LED_CNT), .PIX_W(PIX_W), .GAP_CYC(GAP_CYC),
        .IDLE_CYC(IDLE_CYC), .STEP_CYC(STEP_CYC), .ACK_CYC(ACK_CYC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .frame_in       (frame_in),
        .frame_valid    (frame_valid),
        .drv_busy       (drv_busy),
        .drv_start      (drv_start),
        .drv_data       (drv_data),
        .pattern_active (pattern_active),
        .stall_err      (stall_err),
        .drop_cnt       (drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (drv_start) begin
            st_cyc_q.push_back(cyc);
            st_dat_q.push_back(drv_data);
        end
    end

    // Driver model: busy for BUSY_CYC cycles starting the cycle after a start.
    initial begin
        forever begin
            @(negedge clk);
            if (drv_start && bfm_ack) begin
                @(posedge clk); #1 drv_busy = 1'b1;
                repeat (BUSY_CYC) @(posedge clk);
                #1 drv_busy = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [FW-1:0] rand_frame();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[FW-1:0];
    endfunction

    // Expected chase frame: a lit pixel k positions below the MSB end.
    function automatic logic [FW-1:0] pat_ref(input int k);
        logic [FW-1:0] lit;
        lit = '0;
        lit[FW-1 -: PIX_W] = 9'h1FF;
        return lit >> (k * PIX_W);
    endfunction

    task automatic pulse_frame(input logic [FW-1:0] f);
        @(posedge clk); #1;
        frame_in    = f;
        frame_valid = 1'b1;
        last_fv_cyc = cyc;
        @(posedge clk); #1;
        frame_valid = 1'b0;
    endtask

    task automatic wait_start(input int budget, output bit got, output int c, output logic [FW-1:0] d);
        got = 1'b0;
        c   = -1;
        d   = '0;
        for (int i = 0; i < budget && st_cyc_q.size() == 0; i++) @(negedge clk);
        if (st_cyc_q.size() != 0) begin
            got = 1'b1;
            c   = st_cyc_q.pop_front();
            d   = st_dat_q.pop_front();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++; if (drv_start !== 1'b0) begin n_fail++; $display("FAIL reset_drv_start: got %b expected 0", drv_start); end
        n_tests++; if (drv_data !== '0) begin n_fail++; $display("FAIL reset_drv_data: got %h expected 0", drv_data); end
        n_tests++; if (pattern_active !== 1'b0) begin n_fail++; $display("FAIL reset_pattern_active: got %b expected 0", pattern_active); end
        n_tests++; if (stall_err !== 1'b0) begin n_fail++; $display("FAIL reset_stall_err: got %b expected 0", stall_err); end
        n_tests++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_single_frame();
        logic [FW-1:0] f1, f2, d;
        bit got, seen;
        int n, c, c2, fall;
        f1 = 63'h1_2345_6789_ABCD_EF;
        pulse_frame(f1);
        n = last_fv_cyc;
        wait_start(20, got, c, d);
        n_tests++; if (!got || c != n + 3) begin n_fail++; $display("FAIL single_latency: start cycle %0d expected %0d", c, n + 3); end
        n_tests++; if (d !== f1) begin n_fail++; $display("FAIL single_data: got %h expected %h", d, f1); end
        while (cyc < c + 1) @(negedge clk);
        n_tests++; if (drv_start !== 1'b0) begin n_fail++; $display("FAIL single_pulse_width: drv_start %b one cycle after start, expected 0", drv_start); end
        f2 = rand_frame();
        pulse_frame(f2);
        fall = -1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (drv_busy) seen = 1'b1;
            else if (seen) begin fall = cyc; break; end
        end
        wait_start(40, got, c2, d);
        n_tests++; if (!got || fall < 0 || c2 < fall + GAP_CYC) begin n_fail++; $display("FAIL single_gap: start at %0d, busy fell at %0d, need >= fall+%0d", c2, fall, GAP_CYC); end
        n_tests++; if (d !== f2) begin n_fail++; $display("FAIL single_second_data: got %h expected %h", d, f2); end
        n_tests++; if (drop_cnt !== 8'(exp_drop)) begin n_fail++; $display("FAIL single_drop_cnt: got %0d expected %0d", drop_cnt, exp_drop); end
        while (cyc < c2 + 21) @(negedge clk);
    endtask

    task automatic test_overrun();
        logic [FW-1:0] fa, d;
        logic [FW-1:0] fb[3];
        bit got;
        int c, bad;
        fa = rand_frame();
        pulse_frame(fa);
        wait_start(20, got, c, d);
        n_tests++; if (!got || d !== fa) begin n_fail++; $display("FAIL overrun_first_data: got %h expected %h", d, fa); end
        for (int i = 0; i < 10 && !drv_busy; i++) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            fb[k] = rand_frame();
            pulse_frame(fb[k]);
        end
        exp_drop += 2;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (drv_start) break;
            if (drv_data !== fa) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL overrun_data_hold: %0d cycles with drv_data changed, expected 0", bad); end
        wait_start(5, got, c, d);
        n_tests++; if (!got || d !== fb[2]) begin n_fail++; $display("FAIL overrun_latest_wins: got %h expected %h", d, fb[2]); end
        n_tests++; if (drop_cnt !== 8'(exp_drop)) begin n_fail++; $display("FAIL overrun_drop_cnt: got %0d expected %0d", drop_cnt, exp_drop); end
        repeat (24) @(negedge clk);
        n_tests++; if (st_cyc_q.size() != 0) begin n_fail++; $display("FAIL overrun_extra_start: %0d extra starts, expected 0", st_cyc_q.size()); end
    endtask

    task automatic test_stall();
        logic [FW-1:0] fs, fs2, d;
        bit got;
        int c, c2, n;
        bfm_ack = 1'b0;
        fs = rand_frame();
        pulse_frame(fs);
        wait_start(20, got, c, d);
        n_tests++; if (!got) begin n_fail++; $display("FAIL stall_start: got none expected a start"); end
        while (cyc < c + 3) @(negedge clk);
        n_tests++; if (stall_err !== 1'b0) begin n_fail++; $display("FAIL stall_early: got %b at start+3 expected 0", stall_err); end
        @(negedge clk);
        n_tests++; if (stall_err !== 1'b1) begin n_fail++; $display("FAIL stall_set: got %b at start+4 expected 1", stall_err); end
        bfm_ack = 1'b1;
        repeat (GAP_CYC + 2) @(negedge clk);
        fs2 = rand_frame();
        pulse_frame(fs2);
        n = last_fv_cyc;
        wait_start(20, got, c2, d);
        n_tests++; if (!got || c2 != n + 3 || d !== fs2) begin n_fail++; $display("FAIL stall_recover: start %0d data %h expected %0d %h", c2, d, n + 3, fs2); end
        n_tests++; if (stall_err !== 1'b1) begin n_fail++; $display("FAIL stall_sticky: got %b expected 1", stall_err); end
    endtask

    task automatic test_pattern();
        logic [FW-1:0] fp, d;
        bit got;
        int c, base;
        base = last_fv_cyc;
        while (cyc < base + IDLE_CYC - 5) @(negedge clk);
        n_tests++; if (pattern_active !== 1'b0) begin n_fail++; $display("FAIL pattern_early: got %b expected 0", pattern_active); end
        while (cyc < base + IDLE_CYC + 5) @(negedge clk);
        n_tests++; if (pattern_active !== 1'b1) begin n_fail++; $display("FAIL pattern_enter: got %b expected 1", pattern_active); end
        for (int k = 0; k < LED_CNT + 1; k++) begin
            wait_start(60, got, c, d);
            n_tests++; if (!got || d !== pat_ref(k % LED_CNT)) begin n_fail++; $display("FAIL pattern_step_%0d: got %h expected %h", k, d, pat_ref(k % LED_CNT)); end
        end
        fp = rand_frame();
        pulse_frame(fp);
        @(negedge clk);
        n_tests++; if (pattern_active !== 1'b0) begin n_fail++; $display("FAIL pattern_exit: got %b expected 0", pattern_active); end
        wait_start(40, got, c, d);
        n_tests++; if (!got || d !== fp) begin n_fail++; $display("FAIL pattern_spi_resume: got %h expected %h", d, fp); end
        n_tests++; if (drop_cnt !== 8'(exp_drop)) begin n_fail++; $display("FAIL pattern_drop_cnt: got %0d expected %0d", drop_cnt, exp_drop); end
    endtask

    task automatic test_collision();
        logic [FW-1:0] fc, d;
        bit got, found;
        int c;
        st_cyc_q.delete();
        st_dat_q.delete();
        found = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (pattern_active) begin found = 1'b1; break; end
        end
        n_tests++; if (!found) begin n_fail++; $display("FAIL collision_pattern_reentry: pattern_active never rose, expected 1"); end
        fc = rand_frame();
        frame_in    = fc;
        frame_valid = 1'b1;
        last_fv_cyc = cyc;
        @(negedge clk);
        frame_valid = 1'b0;
        n_tests++; if (pattern_active !== 1'b0) begin n_fail++; $display("FAIL collision_pattern_clear: got %b expected 0", pattern_active); end
        wait_start(30, got, c, d);
        n_tests++; if (!got || d !== fc) begin n_fail++; $display("FAIL collision_spi_wins: got %h expected %h", d, fc); end
        n_tests++; if (drop_cnt !== 8'(exp_drop)) begin n_fail++; $display("FAIL collision_drop_cnt: got %0d expected %0d", drop_cnt, exp_drop); end
        repeat (25) @(negedge clk);
        n_tests++; if (st_cyc_q.size() != 0) begin n_fail++; $display("FAIL collision_extra_start: %0d extra starts, expected 0", st_cyc_q.size()); end
    endtask

    task automatic test_reset_mid_send();
        logic [FW-1:0] fr, fn, d;
        bit got;
        int c, n;
        fr = rand_frame();
        pulse_frame(fr);
        wait_start(30, got, c, d);
        for (int i = 0; i < 10 && !drv_busy; i++) @(negedge clk);
        pulse_frame(rand_frame());
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        exp_drop = 0;
        n_tests++; if (drv_start !== 1'b0) begin n_fail++; $display("FAIL midrst_drv_start: got %b expected 0", drv_start); end
        n_tests++; if (drv_data !== '0) begin n_fail++; $display("FAIL midrst_drv_data: got %h expected 0", drv_data); end
        n_tests++; if (pattern_active !== 1'b0) begin n_fail++; $display("FAIL midrst_pattern_active: got %b expected 0", pattern_active); end
        n_tests++; if (stall_err !== 1'b0) begin n_fail++; $display("FAIL midrst_stall_err: got %b expected 0", stall_err); end
        n_tests++; if (drop_cnt !== 8'(exp_drop)) begin n_fail++; $display("FAIL midrst_drop_cnt: got %0d expected %0d", drop_cnt, exp_drop); end
        st_cyc_q.delete();
        st_dat_q.delete();
        repeat (30) @(negedge clk);
        n_tests++; if (st_cyc_q.size() != 0) begin n_fail++; $display("FAIL midrst_no_start: %0d starts after reset, expected 0", st_cyc_q.size()); end
        fn = rand_frame();
        pulse_frame(fn);
        n = last_fv_cyc;
        wait_start(20, got, c, d);
        n_tests++; if (!got || c != n + 3 || d !== fn) begin n_fail++; $display("FAIL midrst_restart: start %0d data %h expected %0d %h", c, d, n + 3, fn); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_overrun();
        test_stall();
        test_pattern();
        test_collision();
        test_reset_mid_send();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
